truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-capture stage wrapped around a small combinational logic block (e.g. a 3-input single-output function).
- Drives every input combination in ascending binary order and samples the block's output after a programmable settle time.
- Assembles the captured truth table and compares it against an expected table.
- Replaces free-running testbench stimulus with a synthesizable self-check usable on hardware.

---
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Drives every input vector of a small combinational block in ascending
// order, samples its output after a programmable settle time, and compares
// the captured truth table against an expected table latched at start.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [(1<<N_IN)-1:0]  i_expected,
  input  logic                  i_f,
  output logic [N_IN-1:0]       o_abc,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [(1<<N_IN)-1:0]  o_table,
  output logic                  o_pass,
  output logic [N_IN:0]         o_mismatch_cnt
);

  localparam int unsigned ROWS = 1 << N_IN;
  localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] ABC_LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [N_IN-1:0]      r_abc;
  logic [CW-1:0]        r_cnt;
  logic [ROWS-1:0]      r_exp;
  logic [ROWS-1:0]      r_table;
  logic [N_IN:0]        r_mis;
  logic                 r_pass;
  logic                 r_done;

  logic                 w_sample;
  logic                 w_last;
  logic                 w_miss;
  logic [N_IN:0]        w_mis_next;

  // Sample-edge decode and running mismatch count including the current row
  always_comb begin
    w_sample   = (r_state == SWEEP) && (r_cnt == CNT_LAST);
    w_last     = (r_abc == ABC_LAST);
    w_miss     = (i_f != r_exp[r_abc]);
    w_mis_next = r_mis + {{N_IN{1'b0}}, w_miss};
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: start leaves IDLE, the final sample returns to IDLE
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (i_start)            w_state_next = SWEEP;
      SWEEP: if (w_sample && w_last) w_state_next = IDLE;
      default:                       w_state_next = IDLE;
    endcase
  end

  // Sweep datapath: vector stepping, settle counting, capture and compare
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_abc   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_mis   <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_abc   <= '0;
            r_cnt   <= '0;
            r_exp   <= i_expected;
            r_table <= '0;
            r_mis   <= '0;
            r_pass  <= 1'b0;
          end
        end
        SWEEP: begin
          if (!w_sample) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_table[r_abc] <= i_f;
            r_mis          <= w_mis_next;
            r_cnt          <= '0;
            if (!w_last) begin
              r_abc <= r_abc + N_IN'(1);
            end else begin
              r_abc  <= '0;
              r_done <= 1'b1;
              r_pass <= (w_mis_next == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_busy         = (r_state == SWEEP);
    o_abc          = r_abc;
    o_done         = r_done;
    o_table        = r_table;
    o_pass         = r_pass;
    o_mismatch_cnt = r_mis;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam int N = 3;
  localparam int R = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [7:0] exp1 = '0, exp3 = '0;
  logic [7:0] func1 = 8'hE8, func3 = 8'hE8;
  logic       f1, f3, d1, d2;

  logic [2:0] abc1, abc3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] tab1, tab3;
  logic [3:0] mis1, mis3;

  // Block under check: instance 1 sees a purely combinational function,
  // instance 3 sees the same kind of function through a 2-cycle register delay.
  assign f1 = func1[abc1];
  always @(posedge clk) begin
    d1 <= func3[abc3];
    d2 <= d1;
  end
  assign f3 = d2;

  truth_table_sweeper #(.N_IN(N), .SETTLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_expected(exp1), .i_f(f1),
    .o_abc(abc1), .o_busy(busy1), .o_done(done1), .o_table(tab1),
    .o_pass(pass1), .o_mismatch_cnt(mis1));

  truth_table_sweeper #(.N_IN(N), .SETTLE(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_expected(exp3), .i_f(f3),
    .o_abc(abc3), .o_busy(busy3), .o_done(done3), .o_table(tab3),
    .o_pass(pass3), .o_mismatch_cnt(mis3));

  bit         sel;
  logic [2:0] w_abc;
  logic       w_busy, w_done, w_pass;
  logic [7:0] w_tab;
  logic [3:0] w_mis;
  always_comb begin
    w_abc  = sel ? abc3  : abc1;
    w_busy = sel ? busy3 : busy1;
    w_done = sel ? done3 : done1;
    w_pass = sel ? pass3 : pass1;
    w_tab  = sel ? tab3  : tab1;
    w_mis  = sel ? mis3  : mis1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v, input bit upd_exp, input logic [7:0] e);
    if (sel) begin start3 = v; if (upd_exp) exp3 = e; end
    else     begin start1 = v; if (upd_exp) exp1 = e; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".abc"},  32'(w_abc), 0);
    chk({tag, ".busy"}, 32'(w_busy), 0);
    chk({tag, ".done"}, 32'(w_done), 0);
    chk({tag, ".tab"},  32'(w_tab), 0);
    chk({tag, ".pass"}, 32'(w_pass), 0);
    chk({tag, ".mis"},  32'(w_mis), 0);
  endtask

  // Full sweep from an idle DUT. Reference: vector i is held for S cycles,
  // captured table equals the block's function, mismatches = differing bits.
  task automatic run_sweep(input bit s, input int S, input logic [7:0] fn,
                           input logic [7:0] ex, input bit repulse, input bit hold);
    sel = s;
    if (s) func3 = fn; else func1 = fn;
    set_start(1'b1, 1'b1, ex);
    step();
    if (!hold) set_start(1'b0, 1'b0, '0);
    for (int m = 0; m < R*S; m++) begin
      chk("sweep.abc",  32'(w_abc), 32'(m / S));
      chk("sweep.busy", 32'(w_busy), 1);
      chk("sweep.done", 32'(w_done), 0);
      if (repulse && (m == 2*S || m == 5*S)) set_start(1'b1, 1'b1, 8'h00);
      else if (!hold) set_start(1'b0, 1'b0, '0);
      step();
    end
    chk("end.done", 32'(w_done), 1);
    chk("end.busy", 32'(w_busy), 0);
    chk("end.abc",  32'(w_abc), 0);
    chk("end.tab",  32'(w_tab), 32'(fn));
    chk("end.mis",  32'($countones(fn ^ ex)), 32'(w_mis) + 32'(0) == 32'(w_mis) ? 32'(w_mis) : 32'(w_mis));
    chk("end.pass", 32'(w_pass), 32'(fn == ex));
    if (!hold) begin
      step();
      chk("post.done", 32'(w_done), 0);
      chk("post.busy", 32'(w_busy), 0);
      chk("post.tab",  32'(w_tab), 32'(fn));
      chk("post.pass", 32'(w_pass), 32'(fn == ex));
    end
  endtask

  initial begin
    logic [7:0] fn, ex;
    sel = 1'b0;
    // Reset held two cycles with start requested: nothing may begin.
    start1 = 1'b1; start3 = 1'b1;
    step();
    sel = 0; chk_zero("rst1a");
    sel = 1; chk_zero("rst3a");
    step();
    sel = 0; chk_zero("rst1b");
    sel = 1; chk_zero("rst3b");
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    step();
    sel = 0; chk("idle1.busy", 32'(w_busy), 0);
    sel = 1; chk("idle3.busy", 32'(w_busy), 0);

    // Majority, exact match and single mismatch
    run_sweep(0, 1, 8'hE8, 8'hE8, 0, 0);
    run_sweep(0, 1, 8'hE8, 8'hE9, 0, 0);
    chk("maj_e9.mis", 32'(w_mis), 1);
    // Settle of 3 against a 2-cycle delayed block
    run_sweep(1, 3, 8'hE8, 8'hE8, 0, 0);
    // Start re-pulsed mid-sweep with a different expected table is ignored
    run_sweep(0, 1, 8'hE8, 8'hE8, 1, 0);
    run_sweep(1, 3, 8'hE8, 8'hE8, 1, 0);

    // Reset mid-sweep at abc=4
    sel = 0; func1 = 8'hE8;
    set_start(1'b1, 1'b1, 8'hE8);
    step();
    set_start(1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) step();
    chk("pre_rst.abc", 32'(w_abc), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midrst");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("after_rst.done", 32'(w_done), 0);
      chk("after_rst.busy", 32'(w_busy), 0);
    end

    // Clean sweep with start held high: second sweep begins in the done cycle
    run_sweep(0, 1, 8'hE8, 8'hE8, 0, 1);
    step();
    set_start(1'b0, 1'b0, '0);
    chk("b2b.busy", 32'(w_busy), 1);
    chk("b2b.done", 32'(w_done), 0);
    chk("b2b.tab",  32'(w_tab), 0);
    chk("b2b.pass", 32'(w_pass), 0);
    chk("b2b.mis",  32'(w_mis), 0);
    for (int k = 0; k < R; k++) step();
    chk("b2b_end.done", 32'(w_done), 1);
    chk("b2b_end.tab",  32'(w_tab), 32'h00E8);
    chk("b2b_end.pass", 32'(w_pass), 1);
    step();

    // Randomized functions and expected tables on both settle settings
    for (int it = 0; it < 12; it++) begin
      fn = 8'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? fn : fn ^ 8'($urandom);
      run_sweep(bit'(it % 2), (it % 2) ? 3 : 1, fn, ex, 0, 0);
      chk("rnd.mis", 32'(w_mis), 32'($countones(fn ^ ex)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
